// File: rtl/dec_jump_link_ras_if.sv
// dec_jump_link_ras_if: fetch/decode-side request and registered jump-decode results
interface dec_jump_link_ras_if #(parameter int ADDR_W = 40, parameter int PTR_W = 3);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] PC;
  logic [31:0]       Instruction;
  logic              out_valid;
  logic              jal_ena;
  logic              jalr_ena;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] link_addr;
  logic              ret_pred_valid;
  logic [ADDR_W-1:0] ret_pred_addr;
  logic [PTR_W:0]    ras_count;
  modport master (
    output in_valid, stall, flush, PC, Instruction,
    input  out_valid, jal_ena, jalr_ena, jump_target, link_addr, ret_pred_valid, ret_pred_addr, ras_count
  );
  modport slave (
    input  in_valid, stall, flush, PC, Instruction,
    output out_valid, jal_ena, jalr_ena, jump_target, link_addr, ret_pred_valid, ret_pred_addr, ras_count
  );
endinterface

// File: rtl/dec_jump_link_ras.sv
// dec_jump_link_ras: registered JAL/JALR decode with link-hinted circular return-address stack
module dec_jump_link_ras #(
  parameter int ADDR_W    = 40,
  parameter int RAS_DEPTH = 8,
  parameter int PTR_W     = 3
) (
  input logic CLK,
  input logic RST,
  dec_jump_link_ras_if.slave bus
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W:0]    count;
  logic              is_jal, is_jalr, link_rd, link_rs1, acc, push, pop, have;
  logic [4:0]        rd, rs1;
  logic [ADDR_W-1:0] imm, target, link;
  always_comb begin
    rd       = bus.Instruction[11:7];
    rs1      = bus.Instruction[19:15];
    is_jal   = bus.Instruction[6:0] == 7'b1101111;
    is_jalr  = bus.Instruction[6:0] == 7'b1100111 && bus.Instruction[14:12] == 3'b000;
    link_rd  = rd == 5'd1 || rd == 5'd5;
    link_rs1 = rs1 == 5'd1 || rs1 == 5'd5;
    imm      = {{(ADDR_W-20){bus.Instruction[31]}}, bus.Instruction[19:12], bus.Instruction[20],
                bus.Instruction[30:21], 1'b0};
    target   = bus.PC + imm;
    link     = bus.PC + ADDR_W'(4);
    acc      = bus.in_valid & ~bus.stall & ~bus.flush;
    push     = acc & (is_jal | is_jalr) & link_rd;
    pop      = acc & is_jalr & link_rs1 & (~link_rd | rd != rs1);
    have     = count != '0;
  end
  assign bus.ras_count = count;
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.out_valid      <= 1'b0;
      bus.jal_ena        <= 1'b0;
      bus.jalr_ena       <= 1'b0;
      bus.jump_target    <= '0;
      bus.link_addr      <= '0;
      bus.ret_pred_valid <= 1'b0;
      bus.ret_pred_addr  <= '0;
      ptr                <= '0;
      count              <= '0;
    end else begin
      if (acc) begin
        bus.out_valid      <= is_jal | is_jalr;
        bus.jal_ena        <= is_jal;
        bus.jalr_ena       <= is_jalr;
        bus.jump_target    <= target;
        bus.link_addr      <= link;
        bus.ret_pred_valid <= pop & have;
        bus.ret_pred_addr  <= pop & have ? ras[ptr] : '0;
      end else if (bus.flush | ~bus.stall) begin
        bus.out_valid      <= 1'b0;
        bus.jal_ena        <= 1'b0;
        bus.jalr_ena       <= 1'b0;
        bus.ret_pred_valid <= 1'b0;
        bus.ret_pred_addr  <= '0;
      end
      // pop-then-push replaces the top in place, so only the count may move
      if (push & ~pop) begin
        ptr   <= ptr + 1'b1;
        count <= count == FULL ? count : count + 1'b1;
      end else if (pop & ~push & have) begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end else if (pop & push & ~have) begin
        count <= (PTR_W+1)'(1);
      end
    end
  end
  always_ff @(posedge CLK)
    if (!RST && push) ras[pop ? ptr : ptr + 1'b1] <= link;
endmodule

// File: tb/tb_dec_jump_link_ras.sv
// tb_dec_jump_link_ras: directed scenario tasks with hand-computed expectations
module tb_dec_jump_link_ras;
  localparam int AW = 40;
  logic CLK = 1'b0;
  logic RST;
  int n_chk = 0;
  int n_fail = 0;
  dec_jump_link_ras_if #(.ADDR_W(AW), .PTR_W(3)) bus ();
  dec_jump_link_ras #(.ADDR_W(AW), .RAS_DEPTH(8), .PTR_W(3)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  always #5 CLK = ~CLK;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] o);
    return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] i);
    return {i, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic [AW-1:0] pc, input logic [31:0] ins);
    bus.in_valid = 1'b1;
    bus.PC = pc;
    bus.Instruction = ins;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic do_reset;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask
  task automatic test_reset;
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.PC = '0; bus.Instruction = '0;
    do_reset();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_chk++; if ({bus.jal_ena, bus.jalr_ena, bus.ret_pred_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_enables: got %b want 000", {bus.jal_ena, bus.jalr_ena, bus.ret_pred_valid}); end
    n_chk++; if ({bus.jump_target, bus.link_addr, bus.ret_pred_addr} !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", bus.jump_target, bus.link_addr, bus.ret_pred_addr); end
    n_chk++; if (bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.ras_count); end
  endtask
  task automatic test_call_return;
    drive(40'h1000, jal(5'd1, 21'h800));
    n_chk++; if ({bus.out_valid, bus.jal_ena, bus.jalr_ena} !== 3'b110) begin n_fail++; $display("FAIL jal_enables: got %b want 110", {bus.out_valid, bus.jal_ena, bus.jalr_ena}); end
    n_chk++; if (bus.jump_target !== 40'h1800) begin n_fail++; $display("FAIL jal_target: got %h want 1800", bus.jump_target); end
    n_chk++; if (bus.link_addr !== 40'h1004) begin n_fail++; $display("FAIL jal_link: got %h want 1004", bus.link_addr); end
    n_chk++; if (bus.ras_count !== 4'd1 || bus.ret_pred_valid !== 1'b0) begin n_fail++; $display("FAIL jal_push: got count %0d rpv %b want 1 0", bus.ras_count, bus.ret_pred_valid); end
    drive(40'h1800, jalr(5'd0, 5'd1, 12'h0));
    n_chk++; if ({bus.out_valid, bus.jal_ena, bus.jalr_ena} !== 3'b101) begin n_fail++; $display("FAIL ret_enables: got %b want 101", {bus.out_valid, bus.jal_ena, bus.jalr_ena}); end
    n_chk++; if (bus.ret_pred_valid !== 1'b1 || bus.ret_pred_addr !== 40'h1004) begin n_fail++; $display("FAIL ret_pred: got %b %h want 1 1004", bus.ret_pred_valid, bus.ret_pred_addr); end
    n_chk++; if (bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL ret_count: got %0d want 0", bus.ras_count); end
    tick();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.ret_pred_valid !== 1'b0 || bus.link_addr !== 40'h1804) begin n_fail++; $display("FAIL idle_clear: got %b %b %h want 0 0 1804", bus.out_valid, bus.ret_pred_valid, bus.link_addr); end
  endtask
  task automatic test_boundaries;
    drive(40'h0, jal(5'd0, 21'h1FFFFC));
    n_chk++; if (bus.jump_target !== 40'hFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got %h want fffffffffc", bus.jump_target); end
    n_chk++; if (bus.ras_count !== 4'd0 || bus.jal_ena !== 1'b1) begin n_fail++; $display("FAIL nolink_jal: got count %0d jal %b want 0 1", bus.ras_count, bus.jal_ena); end
    drive(40'hFF_FFFF_FFFC, jalr(5'd0, 5'd1, 12'h0));
    n_chk++; if (bus.jalr_ena !== 1'b1 || bus.ret_pred_valid !== 1'b0 || bus.ret_pred_addr !== '0) begin n_fail++; $display("FAIL empty_pop: got %b %b %h want 1 0 0", bus.jalr_ena, bus.ret_pred_valid, bus.ret_pred_addr); end
    n_chk++; if (bus.link_addr !== 40'h0 || bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL link_wrap: got %h %0d want 0 0", bus.link_addr, bus.ras_count); end
    drive(40'h40, 32'h0000_0093);
    n_chk++; if ({bus.out_valid, bus.jal_ena, bus.jalr_ena} !== 3'b000) begin n_fail++; $display("FAIL nonjump: got %b want 000", {bus.out_valid, bus.jal_ena, bus.jalr_ena}); end
    drive(40'h44, jalr(5'd1, 5'd2, 12'h0) | 32'h0000_1000);
    n_chk++; if (bus.out_valid !== 1'b0 || bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL jalr_funct3: got %b %0d want 0 0", bus.out_valid, bus.ras_count); end
  endtask
  task automatic test_overflow;
    logic [AW-1:0] want;
    do_reset();
    for (int k = 1; k <= 9; k++) drive(AW'(k * 256), jal(5'd1, 21'h8));
    n_chk++; if (bus.ras_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", bus.ras_count); end
    for (int k = 9; k >= 2; k--) begin
      want = AW'(k * 256 + 4);
      drive(40'h7000, jalr(5'd0, 5'd5, 12'h0));
      n_chk++; if (bus.ret_pred_valid !== 1'b1 || bus.ret_pred_addr !== want) begin n_fail++; $display("FAIL deep_pop%0d: got %b %h want 1 %h", k, bus.ret_pred_valid, bus.ret_pred_addr, want); end
    end
    n_chk++; if (bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL drained_count: got %0d want 0", bus.ras_count); end
    drive(40'h7000, jalr(5'd0, 5'd1, 12'h0));
    n_chk++; if (bus.ret_pred_valid !== 1'b0) begin n_fail++; $display("FAIL ninth_pop: got %b want 0", bus.ret_pred_valid); end
  endtask
  task automatic test_pop_push;
    do_reset();
    drive(40'h2000, jal(5'd1, 21'h100));
    drive(40'h3000, jalr(5'd5, 5'd1, 12'h0));
    n_chk++; if (bus.ret_pred_valid !== 1'b1 || bus.ret_pred_addr !== 40'h2004) begin n_fail++; $display("FAIL coroutine_pred: got %b %h want 1 2004", bus.ret_pred_valid, bus.ret_pred_addr); end
    n_chk++; if (bus.ras_count !== 4'd1) begin n_fail++; $display("FAIL coroutine_count: got %0d want 1", bus.ras_count); end
    drive(40'h3100, jalr(5'd0, 5'd5, 12'h0));
    n_chk++; if (bus.ret_pred_addr !== 40'h3004 || bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL coroutine_top: got %h %0d want 3004 0", bus.ret_pred_addr, bus.ras_count); end
    drive(40'h3200, jalr(5'd1, 5'd1, 12'h0));
    n_chk++; if (bus.ret_pred_valid !== 1'b0 || bus.ras_count !== 4'd1) begin n_fail++; $display("FAIL same_link_push: got %b %0d want 0 1", bus.ret_pred_valid, bus.ras_count); end
    drive(40'h3300, jalr(5'd1, 5'd5, 12'h0));
    drive(40'h3400, jalr(5'd5, 5'd1, 12'h0));
    n_chk++; if (bus.ret_pred_addr !== 40'h3304 || bus.ras_count !== 4'd1) begin n_fail++; $display("FAIL swap_chain: got %h %0d want 3304 1", bus.ret_pred_addr, bus.ras_count); end
  endtask
  task automatic test_stall_flush;
    do_reset();
    drive(40'h4000, jal(5'd1, 21'h10));
    bus.stall = 1'b1;
    bus.in_valid = 1'b1;
    bus.PC = 40'h5000;
    bus.Instruction = jal(5'd1, 21'h20);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (bus.jal_ena !== 1'b1 || bus.jump_target !== 40'h4010 || bus.ras_count !== 4'd1) begin n_fail++; $display("FAIL stall%0d: got %b %h %0d want 1 4010 1", c, bus.jal_ena, bus.jump_target, bus.ras_count); end
    end
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.ras_count !== 4'd1 || bus.jump_target !== 40'h4010) begin n_fail++; $display("FAIL flush: got %b %0d %h want 0 1 4010", bus.out_valid, bus.ras_count, bus.jump_target); end
    bus.flush = 1'b0;
    tick();
    n_chk++; if (bus.jump_target !== 40'h5020 || bus.ras_count !== 4'd2) begin n_fail++; $display("FAIL after_flush: got %h %0d want 5020 2", bus.jump_target, bus.ras_count); end
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.ras_count !== 4'd2) begin n_fail++; $display("FAIL flush_over_stall: got %b %0d want 0 2", bus.out_valid, bus.ras_count); end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    tick();
    RST = 1'b1;
    bus.stall = 1'b1;
    tick();
    RST = 1'b0;
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    n_chk++; if ({bus.out_valid, bus.jal_ena, bus.ras_count, bus.jump_target, bus.link_addr} !== '0) begin n_fail++; $display("FAIL mid_reset: got %b %b %0d %h %h want all 0", bus.out_valid, bus.jal_ena, bus.ras_count, bus.jump_target, bus.link_addr); end
  endtask
  initial begin
    RST = 1'b1;
    test_reset();
    test_call_return();
    test_boundaries();
    test_overflow();
    test_pop_push();
    test_stall_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
